// File: rtl/async_fifo_main.sv
// async_fifo_main: single-clock FIFO with wrap-bit pointers, registered read data and full/empty flags
module async_fifo_main #(
  parameter int addr_size = 3,
  parameter int word_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [word_width-1:0] data_in,
  output logic [word_width-1:0] data_out,
  output logic                  full,
  output logic                  empty
);
  localparam logic [addr_size:0] one = {{addr_size{1'b0}}, 1'b1};
  logic [word_width-1:0] mem [2**addr_size];
  logic [addr_size:0] wptr, rptr;
  logic do_wr, do_rd;
  assign empty = wptr == rptr;
  assign full = (wptr[addr_size] != rptr[addr_size]) && (wptr[addr_size-1:0] == rptr[addr_size-1:0]);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  always_ff @(posedge clk)
    if (do_wr) mem[wptr[addr_size-1:0]] <= data_in;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      data_out <= '0;
    end else begin
      if (do_wr) wptr <= wptr + one;
      if (do_rd) begin
        data_out <= mem[rptr[addr_size-1:0]];
        rptr <= rptr + one;
      end
    end
endmodule

// File: tb/tb_async_fifo_main.sv
// tb_async_fifo_main: scoreboard bench; driver pushes expected outputs, monitor compares on the following falling edge
module tb_async_fifo_main;
  logic clk = 0, reset = 1, rd = 0, wr = 0;
  logic [7:0] data_in = 0, data_out;
  logic full, empty;
  int checks = 0, errors = 0;
  typedef struct packed {logic [7:0] d; logic f; logic e;} exp_t;
  exp_t exp_q[$];
  exp_t cur;
  logic [7:0] mq[$];
  logic [7:0] ed = 0;
  logic [7:0] v1 [8] = '{104, 105, 95, 116, 104, 101, 114, 101};
  logic [7:0] v2 [8] = '{79, 114, 105, 103, 105, 110, 97, 108};

  async_fifo_main dut (.clk(clk), .reset(reset), .rd(rd), .wr(wr), .data_in(data_in),
                       .data_out(data_out), .full(full), .empty(empty));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      check("data_out", {24'd0, data_out}, {24'd0, cur.d});
      check("full", {31'd0, full}, {31'd0, cur.f});
      check("empty", {31'd0, empty}, {31'd0, cur.e});
    end

  task automatic step(input logic r, input logic w, input logic [7:0] d);
    logic ar, aw;
    @(negedge clk);
    rd = r; wr = w; data_in = d;
    @(posedge clk);
    ar = r && mq.size() > 0;
    aw = w && mq.size() < 8;
    if (ar) ed = mq.pop_front();
    if (aw) mq.push_back(d);
    exp_q.push_back('{ed, mq.size() == 8, mq.size() == 0});
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clk);
    rd = 0; wr = 0;
    #2 reset = 1;
    #1;
    check({name, "_empty"}, {31'd0, empty}, 32'd1);
    check({name, "_full"}, {31'd0, full}, 32'd0);
    check({name, "_dout"}, {24'd0, data_out}, 32'd0);
    #1 reset = 0;
    mq.delete();
    ed = 0;
  endtask

  task automatic settle(input string name, input logic [7:0] d, input logic f, input logic e);
    @(negedge clk);
    rd = 0; wr = 0;
    #1;
    check({name, "_dout"}, {24'd0, data_out}, {24'd0, d});
    check({name, "_full"}, {31'd0, full}, {31'd0, f});
    check({name, "_empty"}, {31'd0, empty}, {31'd0, e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("init_empty", {31'd0, empty}, 32'd1);
    check("init_full", {31'd0, full}, 32'd0);
    check("init_dout", {24'd0, data_out}, 32'd0);
    reset = 0;
    // load some state so the asynchronous reset has something to clear
    step(0, 1, 8'd33);
    step(0, 1, 8'd44);
    step(1, 0, 8'd0);
    settle("pre_reset", 8'd33, 0, 0);
    pulse_reset("async_reset");
    for (int i = 0; i < 8; i++) step(0, 1, v1[i]);
    step(0, 1, 8'd79);
    settle("after_full_write", 8'd0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 8'd0);
    step(1, 0, 8'd0);
    settle("underflow_hold", 8'd101, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 1, v2[i]);
    settle("wrap_full", 8'd101, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 8'd0);
    settle("wrap_drain", 8'd108, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 8'(10 * (i + 1)));
    step(1, 1, 8'd50);
    settle("rw_mid", 8'd10, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 8'd0);
    settle("rw_mid_drain", 8'd50, 0, 1);
    step(1, 1, 8'd60);
    settle("rw_empty", 8'd50, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 8'(61 + i));
    settle("refill", 8'd50, 1, 0);
    step(1, 1, 8'd99);
    settle("rw_full", 8'd60, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 8'd0);
    step(1, 0, 8'd0);
    settle("rw_full_dropped", 8'd67, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 8'(200 + i));
    pulse_reset("mid_reset");
    step(0, 1, 8'd70);
    step(1, 0, 8'd0);
    settle("post_reset", 8'd70, 0, 1);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected outputs, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
